// File: rtl/sp_unit.sv
// sp_unit: stack pointer with push/pop/load/add/init, base/limit checking and sticky faults.
// Rev 1.0
`default_nettype none

module sp_unit #(
  parameter int               WIDTH         = 16,
  parameter int               WORD_SHIFT    = 1,
  parameter logic [WIDTH-1:0] SP_INIT       = '0,
  parameter logic [WIDTH-1:0] STACK_BASE    = '0,
  parameter logic [WIDTH-1:0] STACK_LIMIT   = 16'hFFFE,
  parameter bit               LOCK_ON_FAULT = 1'b1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             spWrite,
  input  logic [2:0]       spOp,
  input  logic [WIDTH-1:0] spIn,
  input  logic             faultClr,
  output logic [WIDTH-1:0] spCur,
  output logic [WIDTH-1:0] spPrev,
  output logic             spOvf,
  output logic             spUnf,
  output logic             spErr,
  output logic             spEmpty,
  output logic             spFull
);

  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_INIT = 3'd5;

  localparam logic [WIDTH:0] c_STEP = (WIDTH+1)'(1) << WORD_SHIFT;

  logic [WIDTH-1:0] r_sp;
  logic [WIDTH-1:0] r_prev;
  logic             r_ovf;
  logic             r_unf;
  logic             r_err;

  logic [WIDTH:0]   w_sp_ext;
  logic [WIDTH:0]   w_cand;
  logic [WIDTH-1:0] w_cand_lo;
  logic             w_down;
  logic             w_wrap;
  logic             w_above;
  logic             w_below;
  logic             w_over;
  logic             w_under;
  logic             w_op_valid;
  logic             w_init;
  logic             w_locked;
  logic             w_eval;
  logic             w_accept;
  logic             w_reject;

  assign w_sp_ext = {1'b0, r_sp};

  // Candidate is one bit wider than SP so that bit WIDTH flags carry/borrow.
  always_comb begin
    w_cand = w_sp_ext;
    w_down = 1'b0;
    case (spOp)
      OP_PUSH: w_cand = w_sp_ext + c_STEP;
      OP_POP: begin
        w_cand = w_sp_ext - c_STEP;
        w_down = 1'b1;
      end
      OP_LOAD: w_cand = {1'b0, spIn};
      OP_ADD: begin
        w_cand = w_sp_ext + {spIn[WIDTH-1], spIn};
        w_down = spIn[WIDTH-1];
      end
      OP_INIT: w_cand = {1'b0, SP_INIT};
      default: ;
    endcase
  end

  assign w_cand_lo = w_cand[WIDTH-1:0];
  assign w_wrap    = w_cand[WIDTH];

  generate
    if (STACK_BASE == '0) begin : g_base_zero
      assign w_below = 1'b0;
    end else begin : g_base_cmp
      assign w_below = (w_cand_lo < STACK_BASE);
    end
    if (STACK_LIMIT == {WIDTH{1'b1}}) begin : g_limit_max
      assign w_above = 1'b0;
    end else begin : g_limit_cmp
      assign w_above = (w_cand_lo > STACK_LIMIT);
    end
  endgenerate

  assign w_over  = w_wrap ? ~w_down : w_above;
  assign w_under = w_wrap ?  w_down : w_below;

  assign w_op_valid = spWrite && (spOp >= OP_PUSH) && (spOp <= OP_INIT);
  assign w_init     = spWrite && (spOp == OP_INIT);
  // A same-cycle faultClr lifts the lock so the accompanying op is evaluated.
  assign w_locked   = LOCK_ON_FAULT && (r_ovf || r_unf) && !faultClr;
  assign w_eval     = w_op_valid && (!w_locked || w_init);
  assign w_accept   = w_eval && (w_init || !(w_over || w_under));
  assign w_reject   = w_eval && !w_init && (w_over || w_under);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_sp   <= SP_INIT;
      r_prev <= SP_INIT;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_prev <= r_sp;
        r_sp   <= w_cand_lo;
      end
      r_err <= w_reject;
      r_ovf <= (r_ovf && !faultClr) || (w_reject && w_over);
      r_unf <= (r_unf && !faultClr) || (w_reject && w_under);
    end
  end

  assign spCur   = r_sp;
  assign spPrev  = r_prev;
  assign spOvf   = r_ovf;
  assign spUnf   = r_unf;
  assign spErr   = r_err;
  assign spEmpty = (r_sp == STACK_BASE);
  assign spFull  = ((w_sp_ext + c_STEP) > {1'b0, STACK_LIMIT});

endmodule

`default_nettype wire

// File: tb/tb_sp_unit.sv
// tb_sp_unit: directed vector table plus async-reset sequence for sp_unit.
// Rev 1.0
`default_nettype none

module tb_sp_unit;

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [15:0] din;
    logic        clr;
    logic [15:0] cur;
    logic [15:0] prev;
    logic        ovf;
    logic        unf;
    logic        err;
    logic        emp;
    logic        full;
  } vec_t;

  logic        clock;
  logic        resetN;
  logic        spWrite;
  logic [2:0]  spOp;
  logic [15:0] spIn;
  logic        faultClr;
  logic [15:0] spCur;
  logic [15:0] spPrev;
  logic        spOvf;
  logic        spUnf;
  logic        spErr;
  logic        spEmpty;
  logic        spFull;

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  sp_unit #(
    .WIDTH(16),
    .WORD_SHIFT(1),
    .SP_INIT(16'd0),
    .STACK_BASE(16'd0),
    .STACK_LIMIT(16'd10),
    .LOCK_ON_FAULT(1'b1)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .spWrite(spWrite),
    .spOp(spOp),
    .spIn(spIn),
    .faultClr(faultClr),
    .spCur(spCur),
    .spPrev(spPrev),
    .spOvf(spOvf),
    .spUnf(spUnf),
    .spErr(spErr),
    .spEmpty(spEmpty),
    .spFull(spFull)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] cur, input logic [15:0] prev,
                         input logic ovf, input logic unf, input logic err,
                         input logic emp, input logic full);
    chk({tag, ".spCur"},   32'(spCur),   32'(cur));
    chk({tag, ".spPrev"},  32'(spPrev),  32'(prev));
    chk({tag, ".spOvf"},   32'(spOvf),   32'(ovf));
    chk({tag, ".spUnf"},   32'(spUnf),   32'(unf));
    chk({tag, ".spErr"},   32'(spErr),   32'(err));
    chk({tag, ".spEmpty"}, 32'(spEmpty), 32'(emp));
    chk({tag, ".spFull"},  32'(spFull),  32'(full));
  endtask

  task automatic addv(input logic wr, input logic [2:0] op, input logic [15:0] din, input logic clr,
                      input logic [15:0] cur, input logic [15:0] prev, input logic ovf,
                      input logic unf, input logic err, input logic emp, input logic full);
    vec_t v;
    v.wr = wr; v.op = op; v.din = din; v.clr = clr;
    v.cur = cur; v.prev = prev; v.ovf = ovf; v.unf = unf;
    v.err = err; v.emp = emp; v.full = full;
    vq.push_back(v);
  endtask

  initial begin
    // wr op din clr | cur prev ovf unf err emp full
    addv(1, 1, 16'h0000, 0,  2,  0, 0, 0, 0, 0, 0);
    addv(1, 1, 16'h0000, 0,  4,  2, 0, 0, 0, 0, 0);
    addv(1, 1, 16'h0000, 0,  6,  4, 0, 0, 0, 0, 0);
    addv(1, 1, 16'h0000, 0,  8,  6, 0, 0, 0, 0, 0);
    addv(1, 1, 16'h0000, 0, 10,  8, 0, 0, 0, 0, 1);
    addv(1, 1, 16'h0000, 0, 10,  8, 1, 0, 1, 0, 1);
    addv(1, 2, 16'h0000, 0, 10,  8, 1, 0, 0, 0, 1);
    addv(1, 2, 16'h0000, 1,  8, 10, 0, 0, 0, 0, 0);
    addv(1, 2, 16'h0000, 0,  6,  8, 0, 0, 0, 0, 0);
    addv(1, 2, 16'h0000, 0,  4,  6, 0, 0, 0, 0, 0);
    addv(1, 2, 16'h0000, 0,  2,  4, 0, 0, 0, 0, 0);
    addv(1, 2, 16'h0000, 0,  0,  2, 0, 0, 0, 1, 0);
    addv(1, 2, 16'h0000, 0,  0,  2, 0, 1, 1, 1, 0);
    addv(1, 3, 16'h0006, 0,  0,  2, 0, 1, 0, 1, 0);
    addv(1, 5, 16'h0000, 0,  0,  0, 0, 1, 0, 1, 0);
    addv(1, 0, 16'h0000, 1,  0,  0, 0, 0, 0, 1, 0);
    addv(1, 3, 16'h0004, 0,  4,  0, 0, 0, 0, 0, 0);
    addv(1, 4, 16'hFFFE, 0,  2,  4, 0, 0, 0, 0, 0);
    addv(1, 4, 16'hFFFC, 0,  2,  4, 0, 1, 1, 0, 0);
    addv(1, 3, 16'h000C, 1,  2,  4, 1, 0, 1, 0, 0);
    addv(1, 0, 16'h0000, 1,  2,  4, 0, 0, 0, 0, 0);
    addv(0, 1, 16'h0000, 0,  2,  4, 0, 0, 0, 0, 0);
    addv(1, 6, 16'h0000, 0,  2,  4, 0, 0, 0, 0, 0);
    addv(1, 7, 16'h0000, 0,  2,  4, 0, 0, 0, 0, 0);
    addv(1, 4, 16'h0004, 0,  6,  2, 0, 0, 0, 0, 0);
    addv(1, 4, 16'h0004, 0, 10,  6, 0, 0, 0, 0, 1);
    addv(1, 4, 16'hFFF8, 0,  2, 10, 0, 0, 0, 0, 0);
    addv(1, 4, 16'hFFFD, 0,  2, 10, 0, 1, 1, 0, 0);
    addv(1, 0, 16'h0000, 1,  2, 10, 0, 0, 0, 0, 0);
    addv(1, 3, 16'h000A, 0, 10,  2, 0, 0, 0, 0, 1);
    addv(1, 3, 16'h000B, 0, 10,  2, 1, 0, 1, 0, 1);
    addv(1, 5, 16'h0000, 1,  0, 10, 0, 0, 0, 1, 0);
    addv(1, 3, 16'h0006, 0,  6,  0, 0, 0, 0, 0, 0);
    addv(1, 3, 16'h000C, 0,  6,  0, 1, 0, 1, 0, 0);

    resetN = 1'b0; spWrite = 1'b0; spOp = 3'd0; spIn = 16'd0; faultClr = 1'b0;
    #12;
    chk_all("reset", 16'd0, 16'd0, 0, 0, 0, 1, 0);
    @(negedge clock);
    resetN = 1'b1;

    foreach (vq[i]) begin
      @(negedge clock);
      spWrite = vq[i].wr; spOp = vq[i].op; spIn = vq[i].din; faultClr = vq[i].clr;
      @(posedge clock);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].cur, vq[i].prev, vq[i].ovf,
              vq[i].unf, vq[i].err, vq[i].emp, vq[i].full);
    end

    // Locked PUSH, then async reset dropped between edges with the op still applied.
    @(negedge clock);
    spWrite = 1'b1; spOp = 3'd1; spIn = 16'd0; faultClr = 1'b0;
    @(posedge clock);
    #1;
    chk_all("locked", 16'd6, 16'd0, 1, 0, 0, 0, 0);
    #2;
    resetN = 1'b0;
    #1;
    chk_all("async_rst", 16'd0, 16'd0, 0, 0, 0, 1, 0);
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
    chk_all("post_rst1", 16'd2, 16'd0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    chk_all("post_rst2", 16'd4, 16'd2, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
